// File: rtl/full_adder_q2_pkg.sv
// Shared types and constants for the full_adder_q2 slice.
package full_adder_q2_pkg;

    // Number of distinct {input_1, input_2, carry_in} vectors.
    localparam int NUM_COMBOS = 8;

    // Input vector ordered {input_1, input_2, carry_in}.
    typedef logic [2:0] combo_t;

    // One-hot mask selecting the coverage bit for a given input vector.
    function automatic logic [NUM_COMBOS-1:0] combo_onehot(input combo_t combo);
        logic [NUM_COMBOS-1:0] one;
        one = {{(NUM_COMBOS-1){1'b0}}, 1'b1};
        return one << combo;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Purely combinational one-bit full adder.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/full_adder_q2.sv
// Full adder with optional registered outputs and sticky input-vector coverage.
module full_adder_q2
    import full_adder_q2_pkg::*;
#(
    parameter bit REG_OUT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  input_1,
    input  logic                  input_2,
    input  logic                  carry_in,
    output logic                  sum,
    output logic                  carry_out,
    output logic                  sum_q,
    output logic                  carry_out_q,
    output logic [NUM_COMBOS-1:0] combo_seen,
    output logic                  all_seen
);

    combo_t combo;

    assign combo = {input_1, input_2, carry_in};

    full_adder_cell u_cell (
        .a    (input_1),
        .b    (input_2),
        .cin  (carry_in),
        .s    (sum),
        .cout (carry_out)
    );

    // Sticky record of every input vector seen on a clock edge; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            combo_seen <= '0;
        end else begin
            combo_seen <= combo_seen | combo_onehot(combo);
        end
    end

    assign all_seen = &combo_seen;

    generate
        if (REG_OUT) begin : g_reg_out
            // One-cycle registered copy of the combinational result.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sum_q       <= 1'b0;
                    carry_out_q <= 1'b0;
                end else begin
                    sum_q       <= sum;
                    carry_out_q <= carry_out;
                end
            end
        end else begin : g_no_reg_out
            assign sum_q       = 1'b0;
            assign carry_out_q = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_full_adder_q2.sv
// Directed, table-driven bench for full_adder_q2 (REG_OUT=1 and REG_OUT=0 builds).
module tb_full_adder_q2;

    logic       clk;
    logic       rst;
    logic [2:0] vin;

    logic       sum1, cout1, sum_q1, cout_q1, all1;
    logic [7:0] seen1;
    logic       sum0, cout0, sum_q0, cout_q0, all0;
    logic [7:0] seen0;

    int checks;
    int failures;

    typedef struct packed {
        logic [2:0] in;
        logic [1:0] exp;   // {carry_out, sum}
    } vec_t;

    vec_t sweep[8];

    full_adder_q2 #(.REG_OUT(1'b1)) dut_reg (
        .clk         (clk),
        .rst         (rst),
        .input_1     (vin[2]),
        .input_2     (vin[1]),
        .carry_in    (vin[0]),
        .sum         (sum1),
        .carry_out   (cout1),
        .sum_q       (sum_q1),
        .carry_out_q (cout_q1),
        .combo_seen  (seen1),
        .all_seen    (all1)
    );

    full_adder_q2 #(.REG_OUT(1'b0)) dut_noreg (
        .clk         (clk),
        .rst         (rst),
        .input_1     (vin[2]),
        .input_2     (vin[1]),
        .carry_in    (vin[0]),
        .sum         (sum0),
        .carry_out   (cout0),
        .sum_q       (sum_q0),
        .carry_out_q (cout_q0),
        .combo_seen  (seen0),
        .all_seen    (all0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Apply a vector on the falling edge, then sample 1 unit after the next rising edge.
    task automatic step(input logic [2:0] v);
        @(negedge clk);
        vin = v;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_seen;
    logic [2:0] order7[7];

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        vin      = 3'b000;

        sweep[0] = '{in: 3'b001, exp: 2'b01};
        sweep[1] = '{in: 3'b010, exp: 2'b01};
        sweep[2] = '{in: 3'b011, exp: 2'b10};
        sweep[3] = '{in: 3'b100, exp: 2'b01};
        sweep[4] = '{in: 3'b101, exp: 2'b10};
        sweep[5] = '{in: 3'b110, exp: 2'b10};
        sweep[6] = '{in: 3'b111, exp: 2'b11};
        sweep[7] = '{in: 3'b000, exp: 2'b00};

        order7[0] = 3'b000; order7[1] = 3'b001; order7[2] = 3'b010;
        order7[3] = 3'b011; order7[4] = 3'b100; order7[5] = 3'b110;
        order7[6] = 3'b111;

        // Reset state, both builds.
        #2;
        chk("rst_sum_q",    {31'd0, sum_q1},  32'd0);
        chk("rst_cout_q",   {31'd0, cout_q1}, 32'd0);
        chk("rst_seen",     {24'd0, seen1},   32'd0);
        chk("rst_all_seen", {31'd0, all1},    32'd0);
        chk("rst_seen_nr",  {24'd0, seen0},   32'd0);

        // Combinational sweep, 20 units per step, while held in reset.
        for (int i = 0; i < 8; i++) begin
            vin = sweep[i].in;
            #10;
            chk($sformatf("comb_r1_%0d", i), {30'd0, cout1, sum1}, {30'd0, sweep[i].exp});
            chk($sformatf("comb_r0_%0d", i), {30'd0, cout0, sum0}, {30'd0, sweep[i].exp});
            #10;
        end
        chk("seen_in_rst", {24'd0, seen1}, 32'd0);

        // Release reset away from the clock edge; first edge captures normally.
        @(negedge clk);
        rst = 1'b0;
        step(3'b111);
        chk("regq_111_sum",  {31'd0, sum_q1},  32'd1);
        chk("regq_111_cout", {31'd0, cout_q1}, 32'd1);
        chk("nr_111_sum_q",  {31'd0, sum_q0},  32'd0);
        chk("nr_111_cout_q", {31'd0, cout_q0}, 32'd0);
        @(negedge clk);
        vin = 3'b000;
        #1;
        chk("hold_between_edges", {30'd0, cout_q1, sum_q1}, 32'd3);
        chk("comb_000_midcycle",  {30'd0, cout1, sum1},     32'd0);
        @(posedge clk);
        #1;
        chk("regq_000", {30'd0, cout_q1, sum_q1}, 32'd0);
        chk("seen_after_regq", {24'd0, seen1}, 32'h81);

        // Coverage: fresh reset, seven vectors skipping 3'b101.
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        exp_seen = 8'h00;
        for (int i = 0; i < 7; i++) begin
            step(order7[i]);
            exp_seen = exp_seen | (8'h01 << order7[i]);
            chk($sformatf("cov_seen_%0d", i),    {24'd0, seen1}, {24'd0, exp_seen});
            chk($sformatf("cov_seen_nr_%0d", i), {24'd0, seen0}, {24'd0, exp_seen});
        end
        chk("cov7_seen", {24'd0, seen1}, 32'hDF);
        chk("cov7_all",  {31'd0, all1},  32'd0);
        step(3'b101);
        chk("cov8_seen",   {24'd0, seen1}, 32'hFF);
        chk("cov8_all",    {31'd0, all1},  32'd1);
        chk("cov8_all_nr", {31'd0, all0},  32'd1);
        step(3'b111);
        chk("sticky_seen", {24'd0, seen1}, 32'hFF);
        chk("sticky_all",  {31'd0, all1},  32'd1);
        chk("sticky_sumq", {31'd0, sum_q1}, 32'd1);

        // Asynchronous reset between edges.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_seen",  {24'd0, seen1},  32'd0);
        chk("async_all",   {31'd0, all1},   32'd0);
        chk("async_sum_q", {31'd0, sum_q1}, 32'd0);
        chk("async_sum",   {31'd0, sum1},   32'd1);
        vin = 3'b110;
        #1;
        chk("async_comb_110", {30'd0, cout1, sum1}, 32'd2);

        // Reset coincident with a rising edge: reset wins.
        @(negedge clk);
        rst = 1'b0;
        vin = 3'b011;
        @(posedge clk);
        rst = 1'b1;
        #1;
        chk("prio_seen",   {24'd0, seen1},   32'd0);
        chk("prio_cout_q", {31'd0, cout_q1}, 32'd0);

        // First edge after release performs a normal capture.
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_seen",   {24'd0, seen1},   32'h08);
        chk("post_rst_cout_q", {31'd0, cout_q1}, 32'd1);
        chk("post_rst_sum_q",  {31'd0, sum_q1},  32'd0);
        chk("post_rst_nr_q",   {30'd0, cout_q0, sum_q0}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
